// File: rtl/mux21_checker.sv
// Parallel checker for N mux21 lanes. It registers each accepted vector in stage 1 and
// compares it on the next edge, collecting error statistics over a run of NVEC vectors.

module mux21_lane_cmp (
  input  logic exp_i,
  input  logic z_i,
  output logic mm_o
);
  assign mm_o = z_i ^ exp_i;
endmodule

module mux21_checker #(
  parameter int N    = 7,
  parameter int CW   = 8,
  parameter int NVEC = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic          a,
  input  logic          b,
  input  logic          s,
  input  logic [N-1:0]  z,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] vec_cnt,
  output logic [N-1:0]  fail_mask,
  output logic [CW-1:0] first_fail_idx,
  output logic          first_fail_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic         a;
    logic         b;
    logic         s;
    logic [N-1:0] z;
  } vec_t;

  localparam logic [CW-1:0] NVEC_C  = CW'(NVEC);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state_q, state_d;
  vec_t          s1_q, s1_d;
  logic          s1_vld_q, s1_vld_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] vec_q, vec_d;
  logic [CW-1:0] err_q, err_d;
  logic [CW-1:0] ffi_q, ffi_d;
  logic          ffv_q, ffv_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;
  logic [N-1:0]  fmask_q, fmask_d;
  logic [N-1:0]  mm;
  logic          exp_bit;
  logic          accept;

  assign exp_bit = s1_q.s ? s1_q.b : s1_q.a;

  for (genvar g = 0; g < N; g++) begin : g_lane
    mux21_lane_cmp u_cmp (
      .exp_i (exp_bit),
      .z_i   (s1_q.z[g]),
      .mm_o  (mm[g])
    );
  end

  // start has priority outside RUN, so a vector presented alongside it is never accepted.
  assign accept = (state_q == RUN) && in_valid && (acc_q < NVEC_C);

  always_comb begin
    state_d  = state_q;
    s1_d     = s1_q;
    s1_vld_d = 1'b0;
    acc_d    = acc_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    fmask_d  = fmask_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          fmask_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          s1_d.a   = a;
          s1_d.b   = b;
          s1_d.s   = s;
          s1_d.z   = z;
          s1_vld_d = 1'b1;
          acc_d    = acc_q + ONE;
        end
        if (s1_vld_q) begin
          vec_d   = vec_q + ONE;
          fmask_d = fmask_q | mm;
          if (|mm) begin
            if (err_q != CNT_MAX) err_d = err_q + ONE;
            if (!ffv_q) begin
              ffi_d = vec_q;
              ffv_d = 1'b1;
            end
          end
          if (vec_d == NVEC_C) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      acc_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      ffi_q    <= '0;
      ffv_q    <= 1'b0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      fmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      acc_q    <= acc_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      ffi_q    <= ffi_d;
      ffv_q    <= ffv_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      fmask_q  <= fmask_d;
    end
  end

  assign busy             = (state_q == RUN);
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign vec_cnt          = vec_q;
  assign fail_mask        = fmask_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;
endmodule

// File: tb/tb_mux21_checker.sv
// Directed and randomized checks of mux21_checker against a run-level reference model.
// A second instance uses small counters to exercise error-count saturation.

module tb_mux21_checker;
  localparam int N = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0, in_valid = 1'b0, a = 1'b0, b = 1'b0, s = 1'b0;
  logic [N-1:0] z = '0;
  logic         busy, done, pass, ffv;
  logic [7:0]   err_cnt, vec_cnt, ffi;
  logic [N-1:0] fail_mask;

  logic         start2 = 1'b0, in_valid2 = 1'b0, a2 = 1'b0, b2 = 1'b0, s2 = 1'b0;
  logic [N-1:0] z2 = '0;
  logic         busy2, done2, pass2, ffv2;
  logic [1:0]   err2, vec2, ffi2;
  logic [N-1:0] mask2;

  mux21_checker #(.N(N), .CW(8), .NVEC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b), .s(s), .z(z),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
    .fail_mask(fail_mask), .first_fail_idx(ffi), .first_fail_valid(ffv)
  );

  mux21_checker #(.N(N), .CW(2), .NVEC(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .a(a2), .b(b2), .s(s2), .z(z2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .vec_cnt(vec2),
    .fail_mask(mask2), .first_fail_idx(ffi2), .first_fail_valid(ffv2)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: a run is a list of per-vector mismatch masks; results reflect
  // the vectors that have become visible, each one edge after being accepted.
  logic [N-1:0] accq[$];
  int n_vis = 0;
  bit m_busy = 0, m_pass = 0, exp_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] expz(input logic fa, input logic fb, input logic fs);
    return {N{fs ? fb : fa}};
  endfunction

  task automatic check_all(input string t);
    int nerr = 0;
    int fi = 0;
    bit fv = 0;
    logic [N-1:0] m = '0;
    for (int i = 0; i < n_vis; i++) begin
      if (accq[i] != '0) begin
        if (!fv) begin fi = i; fv = 1; end
        nerr++;
      end
      m |= accq[i];
    end
    if (nerr > 255) nerr = 255;
    chk({t, ".busy"}, 32'(busy), 32'(m_busy));
    chk({t, ".done"}, 32'(done), 32'(exp_done));
    chk({t, ".pass"}, 32'(pass), 32'(m_pass));
    chk({t, ".err"}, 32'(err_cnt), 32'(nerr));
    chk({t, ".vec"}, 32'(vec_cnt), 32'(n_vis));
    chk({t, ".mask"}, 32'(fail_mask), 32'(m));
    chk({t, ".ffi"}, 32'(ffi), 32'(fi));
    chk({t, ".ffv"}, 32'(ffv), 32'(fv));
  endtask

  task automatic step(input string t, input logic st, input logic v, input logic va,
                      input logic vb, input logic vs, input logic [N-1:0] vz);
    int nerr;
    start = st; in_valid = v; a = va; b = vb; s = vs; z = vz;
    @(posedge clk);
    exp_done = 0;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_pass = 0; accq.delete(); n_vis = 0;
      end
    end else begin
      if (n_vis < accq.size()) begin
        n_vis++;
        if (n_vis == 8) begin
          nerr = 0;
          foreach (accq[i]) if (accq[i] != '0) nerr++;
          m_busy = 0; exp_done = 1; m_pass = (nerr == 0);
        end
      end
      if (v && accq.size() < 8) accq.push_back(vz ^ expz(va, vb, vs));
    end
    #1;
    start = 1'b0; in_valid = 1'b0;
    check_all(t);
  endtask

  task automatic idle(input string t, input int n);
    for (int i = 0; i < n; i++) step(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic vec(input string t, input int i, input logic [N-1:0] flip);
    logic [2:0] ib;
    ib = 3'(i);
    step(t, 1'b0, 1'b1, ib[2], ib[1], ib[0], expz(ib[2], ib[1], ib[0]) ^ flip);
  endtask

  task automatic model_reset();
    m_busy = 0; m_pass = 0; exp_done = 0; accq.delete(); n_vis = 0;
  endtask

  initial begin
    // Reset state
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("post_reset");
    // in_valid in IDLE is ignored
    step("idle_valid", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle("idle_hold", 2);

    // Eight good back-to-back vectors
    step("run1_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) vec("run1_vec", i, '0);
    idle("run1_done", 1);
    chk("run1.done_pulse", 32'(done), 32'd1);
    chk("run1.pass", 32'(pass), 32'd1);
    idle("run1_hold", 2);

    // start with in_valid from DONE; lane 3 corrupted on vector 2
    step("run2_start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) vec("run2_vec", i, (i == 2) ? 7'b0001000 : 7'b0);
    idle("run2_done", 1);
    chk("run2.err", 32'(err_cnt), 32'd1);
    chk("run2.mask", 32'(fail_mask), 32'h08);
    chk("run2.ffi", 32'(ffi), 32'd2);
    idle("run2_hold", 1);

    // Gapped vectors, mid-run start, extra vectors after the eighth
    step("run3_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      vec("run3_vec", i, (i == 5) ? 7'b1000001 : 7'b0);
      if (i < 7) begin
        if (i == 4) step("run3_midstart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        else idle("run3_gap", 1);
        idle("run3_gap", 2);
      end
    end
    for (int i = 0; i < 4; i++) vec("run3_extra", i, 7'h7f);
    chk("run3.vec", 32'(vec_cnt), 32'd8);
    idle("run3_hold", 1);

    // Reset after five vectors, then a clean run
    step("run4_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) vec("run4_vec", i, 7'h01);
    rst = 1'b1; #1;
    model_reset();
    check_all("run4_async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("run4_rst_hold");
    idle("run4_idle", 2);
    step("run5_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) vec("run5_vec", i, '0);
    idle("run5_done", 1);
    chk("run5.pass", 32'(pass), 32'd1);

    // Randomized runs: gaps, stray starts, random lane corruption
    for (int r = 0; r < 12; r++) begin
      step("rnd_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int c = 0; c < 300 && m_busy; c++) begin
        logic [N-1:0] flip;
        logic [2:0] ab;
        ab = 3'($urandom_range(0, 7));
        flip = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        step("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
             ab[2], ab[1], ab[0], expz(ab[2], ab[1], ab[0]) ^ flip);
      end
      chk("rnd.finished", 32'(busy), 32'd0);
      idle("rnd_hold", $urandom_range(0, 3));
    end

    // Small-counter instance: every lane wrong on every vector
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("sat.busy", 32'(busy2), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1'b1; a2 = 1'(i); b2 = 1'b1; s2 = 1'b0;
      z2 = ~expz(1'(i), 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("sat.done", 32'(done2), 32'd1);
    chk("sat.busy_end", 32'(busy2), 32'd0);
    chk("sat.err", 32'(err2), 32'd3);
    chk("sat.vec", 32'(vec2), 32'd3);
    chk("sat.mask", 32'(mask2), 32'h7f);
    chk("sat.ffi", 32'(ffi2), 32'd0);
    chk("sat.ffv", 32'(ffv2), 32'd1);
    chk("sat.pass", 32'(pass2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux21_checker.md
MUX21_CHECKER -- requirements
Module: mux21_checker

Interface
REQ-001 SHALL have parameter N, default 7: number of mux21 output lanes checked in parallel.
REQ-002 SHALL have parameter CW, default 8: width of all counters and indices.
REQ-003 SHALL have parameter NVEC, default 8: number of vectors checked per run (1 to 2^CW-1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a run.
REQ-007 SHALL have port in_valid  input  1  a, b, s, z carry a vector this cycle.
REQ-008 SHALL have ports a, b, s  input  1 each  stimulus applied to the mux21 lanes under test.
REQ-009 SHALL have port z  input  N  lane outputs; bit i is lane i.
REQ-010 SHALL have port busy  output  1  high while the checker is in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-012 SHALL have port pass  output  1  run finished with zero mismatches.
REQ-013 SHALL have port err_cnt  output  CW  vectors with at least one mismatching lane.
REQ-014 SHALL have port vec_cnt  output  CW  vectors compared so far.
REQ-015 SHALL have port fail_mask  output  N  sticky OR of per-lane mismatches.
REQ-016 SHALL have port first_fail_idx  output  CW  index (0-based) of first failing vector.
REQ-017 SHALL have port first_fail_valid  output  1  first_fail_idx holds a valid index.

Function
REQ-018 SHALL compute expected = s ? b : a; lane i mismatches when z[i] != expected.
REQ-019 SHALL implement FSM states IDLE, RUN and DONE.
REQ-020 SHALL move IDLE->RUN and DONE->RUN on start=1, clearing err_cnt, vec_cnt, fail_mask, first_fail_*, pass and the accept counter on the same edge.
REQ-021 SHALL ignore start while in RUN.
REQ-022 SHALL, in RUN, accept a vector on each in_valid=1 edge while accepted count < NVEC, registering a, b, s and z (stage 1).
REQ-023 SHALL ignore in_valid in IDLE, in DONE, and in RUN once NVEC vectors have been accepted.
REQ-024 SHALL compare the registered vector on the next edge (stage 2): increment vec_cnt, OR the mismatch vector into fail_mask, and increment err_cnt if any lane mismatches.
REQ-025 SHALL saturate err_cnt at 2^CW-1.
REQ-026 SHALL, on the first failing vector of a run, load first_fail_idx with that vector's vec_cnt value before increment and set first_fail_valid; later failures do not change either.
REQ-027 SHALL move RUN->DONE on the edge where vec_cnt becomes NVEC, giving a latency of one cycle from the last accepted vector.
REQ-028 SHALL assert done only during the first cycle in DONE.
REQ-029 SHALL set pass on entry to DONE when err_cnt is 0, and hold pass and all results in DONE until the next start or rst.
REQ-030 SHALL let in_valid gaps of any length in RUN stall the run without a timeout.
REQ-031 SHALL, when start and in_valid are both high in IDLE or DONE, take start only and not accept that vector.

Reset
REQ-032 SHALL, on rst=1 at any time including mid-run, asynchronously enter IDLE and drive busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0, fail_mask=0, first_fail_idx=0 and first_fail_valid=0, discarding any vector held in stage 1.
REQ-033 SHALL remain in IDLE after rst deasserts until start.

Verification
REQ-034 SHALL cover: reset, start, 8 back-to-back correct vectors (a,b,s counting 000..111, z replicating expected) -> done pulse one cycle after the last vector, pass=1, err_cnt=0, vec_cnt=8, fail_mask=0.
REQ-035 SHALL cover: same run with z[3] inverted on vector 2 -> err_cnt=1, fail_mask=7'b0001000, first_fail_idx=2, first_fail_valid=1, pass=0.
REQ-036 SHALL cover: vectors with 3-cycle in_valid gaps and 4 extra in_valid after the 8th -> vec_cnt=8, extra vectors ignored; a start pulse mid-run -> no effect.
REQ-037 SHALL cover: rst pulse after 5 vectors -> all outputs 0 immediately and IDLE; a new start then 8 good vectors -> pass=1.
REQ-038 SHALL cover: CW=2, NVEC=3, every vector with all lanes wrong -> err_cnt=3 (saturated), fail_mask=all ones, first_fail_idx=0.
